mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the single pipeline memory port between the instruction-fetch requester (I) and the data-access requester (D). Each transaction is sequenced as grant, issue, wait and complete. The block drives a global `stall` that holds the pipeline until every pending request has completed. It sits between the IF/MEM stages and the memory/cache interface, upstream of the per-stage stall handlers.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; `DATA_W/8` byte-mask bits

- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `i_req`  in  1  fetch request; held until `i_done`
- `i_addr`  in  ADDR_W  fetch address, stable while `i_req`
- `i_rdata`  out  DATA_W  fetch data, valid with `i_done`, held until next `i_done`
- `i_done`  out  1  one-cycle completion pulse for I
- `d_req`  in  1  data request; held until `d_done`
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_wmask`  in  DATA_W/8  byte write mask; all-zero means load
- `d_rdata`  out  DATA_W  load data, valid with `d_done`, held until next `d_done`
- `d_done`  out  1  one-cycle completion pulse for D
- `stall`  out  1  `(i_req & ~i_done) | (d_req & ~d_done)`, combinational
- `mem_req_valid`  out  1  request to memory
- `mem_req_ready`  in  1  memory accepts the request
- `mem_addr`  out  ADDR_W  granted address
- `mem_wdata`  out  DATA_W  granted store data; 0 for I
- `mem_wmask`  out  DATA_W/8  granted mask; 0 for I
- `mem_resp_valid`  in  1  response or write acknowledge, one cycle
- `mem_resp_data`  in  DATA_W  read data, valid with `mem_resp_valid`

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. Only one transaction is outstanding at a time.
- IDLE: if any request is pending, register the grant (I or D) and latch that port's addr/wdata/wmask into the `mem_*` registers, then go to ISSUE. With no pending request, stay in IDLE.
- A request is pending when its `req` is high in IDLE. A `req` still high in the cycle after its done pulse counts as a new request.
- Arbitration when both requests are pending: D wins (fixed priority). See Configuration for the alternative.
- ISSUE: `mem_req_valid`=1. If `mem_req_ready`=1 at the edge, go to WAIT. Otherwise stay in ISSUE with all `mem_*` outputs stable.
- WAIT: `mem_req_valid`=0. When `mem_resp_valid`=1, capture `mem_resp_data` into the granted port's rdata register and go to DONE.
  - For stores the data is captured but is don't-care.
- DONE: pulse the granted port's done for one cycle, then return to IDLE.
- `mem_resp_valid` outside WAIT is ignored and no state changes.
- A requester that drops `req` mid-transaction does not abort it. The transaction completes and the done pulse is still issued.
- The non-granted requester keeps `stall` asserted throughout and is served in the next IDLE.

## Timing
- Reset (async): state=IDLE, `mem_req_valid`=0, `mem_addr`/`mem_wdata`/`mem_wmask`=0, `i_done`/`d_done`=0, `i_rdata`/`d_rdata`=0, and the round-robin pointer selects I as last granted.
- During reset, `stall` = `i_req | d_req`.
- Minimum latency for one request: `req` seen in cycle 0, ISSUE in cycle 1 (ready=1), `mem_resp_valid` in cycle 2, done in cycle 3. Four cycles from `req` to done.
- `stall` falls combinationally in the done cycle so the pipeline advances on that edge.
- If both requests arrive in cycle 0, the loser's done is no earlier than cycle 7. There is one IDLE cycle between transactions.
- Reset asserted mid-transaction aborts it immediately. No done pulse is issued, and a later stray `mem_resp_valid` is ignored.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: when both requests are pending in IDLE, grant the port not granted last. After reset the first tie goes to D. A single pending request is always granted.
- `ARB_ROUND_ROBIN_EN` undefined: fixed priority, D before I. The last-grant register is not built.

## Test plan
- I load only: `i_req`=1, `i_addr`=0x100, ready=1, resp in the first WAIT cycle with data 0xDEADBEEF -> `mem_addr`=0x100 in cycle 1, `i_done` in cycle 3 with `i_rdata`=0xDEADBEEF, `stall` high in cycles 0–2.
- D store with backpressure: `d_wmask`=0xF, `d_wdata`=0x12345678, ready low for 3 cycles -> `mem_req_valid` high for 4 cycles with stable outputs, then a single `d_done` after resp.
- Simultaneous I and D, fixed priority: D is served first. `d_done` and then `i_done` ≥4 cycles later, and `stall` stays high until `i_done`.
- Same stimulus with `ARB_ROUND_ROBIN_EN` for 2 back-to-back tie rounds -> grant order D, I, D, I.
- Spurious `mem_resp_valid` in IDLE and ISSUE -> no done pulses and rdata unchanged.
- Reset asserted in WAIT, then resp arrives after reset -> all outputs zero, no done pulse, FSM in IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch (I) and data (D) requesters
// Optional round-robin tie-break enabled by defining ARB_ROUND_ROBIN_EN; default is fixed D-first priority.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_done,
    input  logic                d_req,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wmask,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_done,
    output logic                stall,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_data
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t state;
    logic   grant_d;
    logic   pick_d;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d;

    // On a tie, D wins unless it was the port granted last.
    always_comb begin
        pick_d = d_req & (~i_req | ~last_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_d <= 1'b0;
        end else if (state == IDLE && (i_req | d_req)) begin
            last_d <= pick_d;
        end
    end
`else
    always_comb begin
        pick_d = d_req;
    end
`endif

    // Done pulses are registered, so stall drops in the same cycle the pulse is visible.
    assign stall = (i_req & ~i_done) | (d_req & ~d_done);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            grant_d       <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
            i_done        <= 1'b0;
            d_done        <= 1'b0;
            i_rdata       <= '0;
            d_rdata       <= '0;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req | d_req) begin
                        grant_d       <= pick_d;
                        mem_req_valid <= 1'b1;
                        state         <= ISSUE;
                        if (pick_d) begin
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_wmask <= d_wmask;
                        end else begin
                            mem_addr  <= i_addr;
                            mem_wdata <= '0;
                            mem_wmask <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        if (grant_d) begin
                            d_rdata <= mem_resp_data;
                        end else begin
                            i_rdata <= mem_resp_data;
                        end
                        d_done <= grant_d;
                        i_done <= ~grant_d;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
